// File: rtl/seg_msg_scheduler.sv
// seg_msg_scheduler: shares the 4-digit 7-segment display between three
// prioritised message requesters and a background value. A granted message
// is held for HOLD_CYCLES, followed by GAP_CYCLES of blank, then background.
// Optional build macro: SEG_MSG_BLINK_EN (requester 0 messages blink with
// half-period BLINK_HALF).
module seg_msg_scheduler #(
  parameter int unsigned HOLD_CYCLES = 100_000_000,
  parameter int unsigned GAP_CYCLES  = 10_000_000,
  parameter int unsigned BLINK_HALF  = 25_000_000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] base_data,
  input  logic [2:0]  req_valid,
  input  logic [47:0] req_data,
  output logic [2:0]  req_ready,
  output logic        busy,
  output logic [1:0]  active_id,
  output logic [15:0] seg_data
);

  localparam int unsigned HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam int unsigned GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_CYCLES - 1);
  localparam logic [GW-1:0] GAP_LOAD  = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  typedef enum logic [1:0] {IDLE, SHOW, GAP} state_t;

  state_t        state, state_nx;
  logic [HW-1:0] hold_cnt, hold_nx;
  logic [GW-1:0] gap_cnt, gap_nx;
  logic [15:0]   msg_reg, msg_nx, seg_nx;
  logic [1:0]    id_nx;
  logic          xfer;
  logic [1:0]    xfer_id;
  logic [15:0]   xfer_word;
  logic [15:0]   idle_entry_word;

`ifdef SEG_MSG_BLINK_EN
  localparam int unsigned BW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
  localparam logic [BW-1:0] BLINK_LOAD = BW'((BLINK_HALF > 0) ? BLINK_HALF - 1 : 0);
  logic [BW-1:0] blink_cnt, blink_cnt_nx;
  logic          blink_off, blink_off_nx;
`endif

  assign busy = (state != IDLE);

  // Grant: lowest asserted index while idle; only requester 0 may preempt a
  // lower-priority message during SHOW; nothing is granted in reset or GAP.
  always_comb begin
    req_ready = '0;
    if (reset_n) begin
      case (state)
        IDLE: begin
          if (req_valid[0])      req_ready = 3'b001;
          else if (req_valid[1]) req_ready = 3'b010;
          else if (req_valid[2]) req_ready = 3'b100;
        end
        SHOW: if (active_id != 2'd0 && req_valid[0]) req_ready = 3'b001;
        default: ;
      endcase
    end
  end

  // Decode the accepted requester and its message word.
  always_comb begin
    xfer    = |(req_valid & req_ready);
    xfer_id = 2'd2;
    if (req_ready[0])      xfer_id = 2'd0;
    else if (req_ready[1]) xfer_id = 2'd1;
    case (xfer_id)
      2'd0:    xfer_word = req_data[15:0];
      2'd1:    xfer_word = req_data[31:16];
      default: xfer_word = req_data[47:32];
    endcase
    // A request still pending when IDLE is re-entered is granted next cycle;
    // keeping the display blank for that cycle avoids a background flash.
    idle_entry_word = (|req_valid) ? '1 : base_data;
  end

  // Next-state and next-output computation.
  always_comb begin
    state_nx = state;
    hold_nx  = hold_cnt;
    gap_nx   = gap_cnt;
    msg_nx   = msg_reg;
    id_nx    = active_id;
    seg_nx   = seg_data;
`ifdef SEG_MSG_BLINK_EN
    blink_cnt_nx = blink_cnt;
    blink_off_nx = blink_off;
`endif
    if (xfer) begin
      // Fresh grant from IDLE or a preemption in SHOW: both restart the hold.
      state_nx = SHOW;
      msg_nx   = xfer_word;
      id_nx    = xfer_id;
      hold_nx  = HOLD_LOAD;
      seg_nx   = xfer_word;
`ifdef SEG_MSG_BLINK_EN
      blink_cnt_nx = BLINK_LOAD;
      blink_off_nx = 1'b0;
`endif
    end else begin
      case (state)
        IDLE: seg_nx = base_data;
        SHOW: begin
          if (hold_cnt == '0) begin
            id_nx = 2'd3;
            if (GAP_CYCLES > 0) begin
              state_nx = GAP;
              gap_nx   = GAP_LOAD;
              seg_nx   = '1;
            end else begin
              state_nx = IDLE;
              seg_nx   = idle_entry_word;
            end
          end else begin
            hold_nx = hold_cnt - 1'b1;
            seg_nx  = msg_reg;
`ifdef SEG_MSG_BLINK_EN
            if (blink_cnt == '0) begin
              blink_cnt_nx = BLINK_LOAD;
              blink_off_nx = ~blink_off;
            end else begin
              blink_cnt_nx = blink_cnt - 1'b1;
            end
            if (active_id == 2'd0 && blink_off_nx) seg_nx = '1;
`endif
          end
        end
        GAP: begin
          seg_nx = '1;
          if (gap_cnt == '0) begin
            state_nx = IDLE;
            seg_nx   = idle_entry_word;
          end else begin
            gap_nx = gap_cnt - 1'b1;
          end
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  // State and output registers with asynchronous blanking reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      hold_cnt  <= '0;
      gap_cnt   <= '0;
      msg_reg   <= '0;
      active_id <= 2'd3;
      seg_data  <= '1;
`ifdef SEG_MSG_BLINK_EN
      blink_cnt <= '0;
      blink_off <= 1'b0;
`endif
    end else begin
      state     <= state_nx;
      hold_cnt  <= hold_nx;
      gap_cnt   <= gap_nx;
      msg_reg   <= msg_nx;
      active_id <= id_nx;
      seg_data  <= seg_nx;
`ifdef SEG_MSG_BLINK_EN
      blink_cnt <= blink_cnt_nx;
      blink_off <= blink_off_nx;
`endif
    end
  end

endmodule

// File: tb/tb_seg_msg_scheduler.sv
// Testbench for seg_msg_scheduler: directed scenarios plus randomized
// requester traffic, checked against a timeline-based reference model.
module tb_seg_msg_scheduler;

  localparam int unsigned HOLD  = 8;
  localparam int unsigned GAP   = 2;
  localparam int unsigned BLINK = 2;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [15:0] base_data;
  logic [2:0]  req_valid;
  logic [47:0] req_data;
  logic [2:0]  req_ready;
  logic        busy;
  logic [1:0]  active_id;
  logic [15:0] seg_data;

  always #5 clk = ~clk;

  seg_msg_scheduler #(
    .HOLD_CYCLES(HOLD),
    .GAP_CYCLES (GAP),
    .BLINK_HALF (BLINK)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .base_data(base_data),
    .req_valid(req_valid),
    .req_data (req_data),
    .req_ready(req_ready),
    .busy     (busy),
    .active_id(active_id),
    .seg_data (seg_data)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: mode 0 idle, 1 showing, 2 gap; m_k = cycles of the
  // message already shown, m_g = gap cycles already shown.
  int          m_mode;
  int          m_k;
  int          m_g;
  int          m_id;
  logic [15:0] m_msg;
  logic [15:0] m_seg;
  logic [2:0]  last_xfer;

  task automatic model_reset();
    m_mode = 0; m_k = 0; m_g = 0; m_id = 3;
    m_msg = 16'h0000; m_seg = 16'hFFFF;
  endtask

  function automatic logic [2:0] exp_ready();
    if (!reset_n) return 3'b000;
    if (m_mode == 0) begin
      for (int i = 0; i < 3; i++)
        if (req_valid[i]) return 3'(1 << i);
      return 3'b000;
    end
    if (m_mode == 1 && m_id != 0 && req_valid[0]) return 3'b001;
    return 3'b000;
  endfunction

  function automatic logic [15:0] exp_seg();
    if (m_mode == 1) begin
`ifdef SEG_MSG_BLINK_EN
      if (m_id == 0 && ((m_k / BLINK) % 2 == 1)) return 16'hFFFF;
`endif
      return m_msg;
    end
    return m_seg;
  endfunction

  task automatic model_edge(input logic [2:0] rdy);
    logic [2:0] x;
    int id;
    x = rdy & req_valid;
    last_xfer = x;
    if (x != 3'b000) begin
      id = x[0] ? 0 : (x[1] ? 1 : 2);
      m_mode = 1; m_id = id; m_k = 0;
      m_msg = 16'(req_data >> (16 * id));
    end else begin
      case (m_mode)
        0: m_seg = base_data;
        1: begin
          if (m_k + 1 == int'(HOLD)) begin
            m_id = 3;
            if (GAP > 0) begin
              m_mode = 2; m_g = 0; m_seg = 16'hFFFF;
            end else begin
              m_mode = 0; m_seg = (|req_valid) ? 16'hFFFF : base_data;
            end
          end else begin
            m_k++;
          end
        end
        default: begin
          if (m_g + 1 == int'(GAP)) begin
            m_mode = 0; m_seg = (|req_valid) ? 16'hFFFF : base_data;
          end else begin
            m_g++;
          end
        end
      endcase
    end
  endtask

  // One clock: check grant mid-cycle, advance model at the edge, check outputs.
  task automatic step();
    logic [2:0] r;
    #1;
    r = exp_ready();
    check("req_ready", 16'(req_ready), 16'(r));
    @(posedge clk);
    model_edge(r);
    @(negedge clk);
    check("seg_data", seg_data, exp_seg());
    check("active_id", 16'(active_id), 16'((m_mode == 1) ? m_id : 3));
    check("busy", 16'(busy), 16'(m_mode != 0));
  endtask

  // Directed stepping: a requester drops valid once its message is taken.
  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      step();
      req_valid = req_valid & ~last_xfer;
    end
  endtask

  int cnt_a;
  int cnt_b;

  initial begin
    reset_n = 1'b0; base_data = 16'h1234; req_valid = 3'b000; req_data = '0;
    last_xfer = 3'b000;
    model_reset();

    // Reset values while reset is held.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_seg", seg_data, 16'hFFFF);
      check("rst_id", 16'(active_id), 16'd3);
      check("rst_busy", 16'(busy), 16'd0);
      check("rst_ready", 16'(req_ready), 16'd0);
    end
    reset_n = 1'b1;
    step();
    check("base_after_reset", seg_data, 16'h1234);

    // Single requester 1 message: hold and busy lengths.
    req_data[31:16] = 16'h900D; req_valid = 3'b010;
    cnt_a = 0; cnt_b = 0;
    for (int i = 0; i < 14; i++) begin
      run(1);
      if (seg_data == 16'h900D) cnt_a++;
      if (busy) cnt_b++;
    end
    check("hold_len", 16'(cnt_a), 16'(HOLD));
    check("busy_len", 16'(cnt_b), 16'(HOLD + GAP));
    check("back_to_base", seg_data, 16'h1234);

    // Two simultaneous requesters: priority order, no background between.
    req_data[31:16] = 16'h900D; req_data[47:32] = 16'h9090; req_valid = 3'b110;
    cnt_a = 0; cnt_b = 0;
    for (int i = 0; i < 30; i++) begin
      run(1);
      if (seg_data == 16'h9090) cnt_a++;
      if (seg_data == 16'h1234 && req_valid != 3'b000) cnt_b++;
    end
    check("second_hold_len", 16'(cnt_a), 16'(HOLD));
    check("no_base_between", 16'(cnt_b), 16'd0);

    // Preemption of requester 2 by requester 0 on the third show cycle.
    req_data[47:32] = 16'h9090; req_valid = 3'b100;
    run(1);
    run(2);
    req_data[15:0] = 16'hCE0F; req_valid[0] = 1'b1;
    #1;
    check("preempt_ready", 16'(req_ready), 16'h0001);
    run(1);
    check("preempt_id", 16'(active_id), 16'd0);
    cnt_a = 0;
    for (int i = 0; i < 14; i++) begin
      run(1);
      if (seg_data == 16'h9090) cnt_a++;
    end
    check("dropped_msg", 16'(cnt_a), 16'd0);

    // Asynchronous reset during the fourth show cycle.
    req_data[31:16] = 16'h900D; req_valid = 3'b010;
    run(1);
    run(3);
    #2 reset_n = 1'b0;
    #1;
    check("async_seg", seg_data, 16'hFFFF);
    check("async_id", 16'(active_id), 16'd3);
    check("async_busy", 16'(busy), 16'd0);
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
    run(2);

    // Requester 0 message (blinks when the optional feature is built in).
    req_data[15:0] = 16'hCE0F; req_valid = 3'b001;
    run(14);

    // Randomized traffic honouring the valid/data hold rule.
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < 3; i++) begin
        if (!req_valid[i] && $urandom_range(0, 9) == 0) begin
          req_valid[i] = 1'b1;
          req_data[16*i +: 16] = 16'($urandom);
        end
      end
      if ($urandom_range(0, 15) == 0) base_data = 16'($urandom);
      step();
      for (int i = 0; i < 3; i++) begin
        if (last_xfer[i]) begin
          if ($urandom_range(0, 1) == 0) req_valid[i] = 1'b0;
          else req_data[16*i +: 16] = 16'($urandom);
        end
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
